// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns a held word request into ce/oe/we timing.
// Partial-word writes become read-modify-write because the SRAM has no byte enables.
module sram_ctrl #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic [19:0] ram_addr,
  inout  wire  [31:0] ram_data,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] READ_LOAD  = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, READ, RMW_READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ce_q, ce_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          drive_q, drive_d;
  logic          ack_q, ack_d;
  logic [31:0]   merged;
  logic          unused_addr;

  assign unused_addr = ^{addr_i[31:22], addr_i[1:0]};

  always_comb begin
    merged = ram_data;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i]) merged[8*i +: 8] = wbuf_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d = addr_i[21:2];
          sel_d  = sel_i;
          wbuf_d = data_i;
          if (!we_i) begin
            state_d = READ;
            cnt_d   = READ_LOAD;
          end else if (sel_i == 4'hF) begin
            state_d = WR_SETUP;
          end else if (sel_i == 4'h0) begin
            state_d = ACK;
          end else begin
            state_d = RMW_READ;
            cnt_d   = READ_LOAD;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          rdata_d = ram_data;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RMW_READ: begin
        if (cnt_q == '0) begin
          wbuf_d  = merged;
          state_d = WR_SETUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WRITE_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_HOLD: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so the pins change together with the state.
  always_comb begin
    ce_d    = !(state_d inside {READ, RMW_READ, WR_SETUP, WR_PULSE, WR_HOLD});
    oe_d    = !(state_d inside {READ, RMW_READ});
    we_d    = !(state_d == WR_PULSE);
    drive_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    ack_d   = (state_d == ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
    end
  end

  assign ram_data = drive_q ? wbuf_q : 'z;
  assign ram_addr = addr_q;
  assign ram_ce   = ce_q;
  assign ram_oe   = oe_q;
  assign ram_we   = we_q;
  assign ack_o    = ack_q;
  assign data_o   = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural asynchronous SRAM on the bus.
// Stimulus pushes expected ack cycle, data_o and strobe counts; the monitor checks on each ack.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ram_ce, ram_oe, ram_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ce_cnt = 0, oe_cnt = 0, we_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          ack_cyc;
    int          ce, oe, we;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:(1<<20)-1];

  sram_ctrl #(.READ_WAIT(2), .WRITE_WAIT(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .sel_i(sel_i), .data_o(data_o), .ack_o(ack_o),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce(ram_ce),
    .ram_oe(ram_oe), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives the bus while selected and output-enabled, stores while we is low.
  assign ram_data = (!ram_ce && !ram_oe) ? mem[ram_addr] : 'z;
  always @(negedge clk) begin
    if (!ram_ce && !ram_we) mem[ram_addr] <= ram_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: strobe counts per transaction, oe/we exclusivity, scoreboard pop on ack.
  always @(negedge clk) begin
    if (rst) begin
      ce_cnt = 0;
      oe_cnt = 0;
      we_cnt = 0;
    end else begin
      if (!ram_ce) ce_cnt++;
      if (!ram_oe) oe_cnt++;
      if (!ram_we) we_cnt++;
      assert (ram_oe || ram_we) else begin
        failures++;
        $display("[TB] FAIL oe_we_overlap: oe=%0b we=%0b at cycle %0d", ram_oe, ram_we, cyc);
      end
      if (ack_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ack: ack at cycle %0d with no pending request", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput({e.name, "_ack_cycle"}, cyc, e.ack_cyc);
          checkOutput({e.name, "_data_o"}, data_o, e.data);
          checkOutput({e.name, "_ce_cycles"}, ce_cnt, e.ce);
          checkOutput({e.name, "_oe_cycles"}, oe_cnt, e.oe);
          checkOutput({e.name, "_we_cycles"}, we_cnt, e.we);
        end
        ce_cnt = 0;
        oe_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic waitAck(input string name, output int ack_at);
    ack_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_o) begin
        ack_at = cyc;
        break;
      end
    end
    if (ack_at < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: no ack within 40 cycles, required one", name);
    end
  endtask

  task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel, input int lat,
                               input logic [31:0] exp_data, input int e_ce, input int e_oe,
                               input int e_we, input bit hold_req, output int ack_at);
    exp_t e;
    @(negedge clk);
    req_i  = 1'b1;
    we_i   = wr;
    addr_i = addr;
    data_i = data;
    sel_i  = sel;
    @(posedge clk);
    #1;
    e.name = name; e.data = exp_data; e.ack_cyc = cyc + lat - 1;
    e.ce = e_ce; e.oe = e_oe; e.we = e_we;
    exp_q.push_back(e);
    checkOutput({name, "_ram_addr"}, {12'h0, ram_addr}, {12'h0, addr[21:2]});
    // Inputs are scrambled after acceptance; the controller must use its latched copies.
    addr_i = 32'h0;
    data_i = ~data;
    sel_i  = ~sel;
    waitAck(name, ack_at);
    if (!hold_req) req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ack_a, ack_b;
    exp_t e;
    mem[20'h00004] = 32'hDEADBEEF;
    mem[20'h00010] = 32'hCAFEF00D;
    mem[20'h00014] = 32'h11223344;
    mem[20'hFFFFF] = 32'h0BADCAFE;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ce", {31'h0, ram_ce}, 32'h1);
    checkOutput("reset_oe", {31'h0, ram_oe}, 32'h1);
    checkOutput("reset_we", {31'h0, ram_we}, 32'h1);
    checkOutput("reset_ack", {31'h0, ack_o}, 32'h0);
    checkOutput("reset_data_o", data_o, 32'h0);
    checkOutput("reset_ram_addr", {12'h0, ram_addr}, 32'h0);
    rst = 1'b0;

    applyStimulus("rd_word4", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'hDEADBEEF, 2, 2, 0, 1'b0, ack_a);
    applyStimulus("wr_full", 1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 5, 32'hDEADBEEF, 4, 0, 2, 1'b0, ack_a);
    checkOutput("mem_after_full", mem[20'h00008], 32'h12345678);
    applyStimulus("rd_back", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3, 32'h12345678, 2, 2, 0, 1'b0, ack_a);
    applyStimulus("wr_part", 1'b1, 32'h0000_0050, 32'h0000AB00, 4'b0010, 7, 32'h12345678, 6, 2, 2, 1'b0, ack_a);
    checkOutput("mem_after_part", mem[20'h00014], 32'h1122AB44);
    applyStimulus("wr_sel0", 1'b1, 32'h0000_0050, 32'hFFFFFFFF, 4'h0, 1, 32'h12345678, 0, 0, 0, 1'b0, ack_a);
    checkOutput("mem_after_sel0", mem[20'h00014], 32'h1122AB44);
    applyStimulus("rd_hibits", 1'b0, 32'hFFC0_0050, 32'h0, 4'hF, 3, 32'h1122AB44, 2, 2, 0, 1'b0, ack_a);

    // Reset in the middle of the write pulse: strobes released, no ack, data_o cleared.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0060; data_i = 32'h5A5A5A5A; sel_i = 4'hF;
    ack_b = 0;
    for (int i = 0; i < 10 && ack_b == 0; i++) begin
      @(negedge clk);
      if (!ram_we) ack_b = 1;
    end
    checkOutput("abort_saw_we_pulse", ack_b, 1);
    rst = 1'b1;
    req_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_we", {31'h0, ram_we}, 32'h1);
    checkOutput("abort_ce", {31'h0, ram_ce}, 32'h1);
    checkOutput("abort_oe", {31'h0, ram_oe}, 32'h1);
    checkOutput("abort_ack", {31'h0, ack_o}, 32'h0);
    checkOutput("abort_data_o", data_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("rd_after_abort", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'hCAFEF00D, 2, 2, 0, 1'b0, ack_a);

    // Back-to-back reads with req held: B is accepted two edges after A's ack edge.
    applyStimulus("rd_b2b_a", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'hDEADBEEF, 2, 2, 0, 1'b1, ack_a);
    addr_i = 32'h003F_FFFC;
    we_i = 1'b0;
    e.name = "rd_b2b_b"; e.data = 32'h0BADCAFE; e.ack_cyc = ack_a + 4;
    e.ce = 2; e.oe = 2; e.we = 0;
    exp_q.push_back(e);
    waitAck("rd_b2b_b", ack_b);
    req_i = 1'b0;

    repeat (6) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
